// File: rtl/wb_regfile.sv
// wb_regfile: writeback end of the pipeline.
// - Commits the MEM/WB writeback bundle into a 32x32 register file with
//   per-byte write enables.
// - Serves two combinational read ports to ID, with a WB->ID bypass.
// - Produces a one-cycle-delayed commit trace and a running write count.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int WE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WE_W-1:0]   wb_wreg,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic [31:0]       wb_pc,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [31:0]       debug_wb_pc,
  output logic [WE_W-1:0]   debug_wb_rf_wen,
  output logic [ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata,
  output logic [31:0]       commit_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  // Byte-wise merge: bytes whose enable is set come from new_v, the rest
  // keep old_v. Shared by the write path and both bypass paths so the
  // value a reader sees in the WB cycle equals what gets stored.
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [WE_W-1:0]   we
  );
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int i = 0; i < WE_W; i++) begin
      if (we[i]) begin
        res[i*8 +: 8] = new_v[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_v[i*8 +: 8];
      end
    end
    return res;
  endfunction

  logic [DATA_W-1:0] regs_r [NREG];
  logic [WE_W-1:0]   eff_we_s;
  logic              wr_act_s;
  logic [DATA_W-1:0] merged_s;
  logic [DATA_W-1:0] rdata1_s;
  logic [DATA_W-1:0] rdata2_s;

  logic [31:0]       dbg_pc_r;
  logic [WE_W-1:0]   dbg_wen_r;
  logic [ADDR_W-1:0] dbg_wnum_r;
  logic [DATA_W-1:0] dbg_wdata_r;
  logic [31:0]       cnt_r;

  // Effective write enables: reset and writes to r0 are squashed here so
  // storage, trace, counter and bypass all agree on what commits.
  always_comb begin
    eff_we_s = {WE_W{1'b0}};
    if (!rst && (wb_wd != {ADDR_W{1'b0}})) begin
      eff_we_s = wb_wreg;
    end else begin
      eff_we_s = {WE_W{1'b0}};
    end
    wr_act_s = (eff_we_s != {WE_W{1'b0}});
    merged_s = byte_merge(regs_r[wb_wd], wb_wdata, eff_we_s);
  end

  // Read port 1: zero in reset / disabled / r0, bypass from WB on a hit.
  always_comb begin
    rdata1_s = {DATA_W{1'b0}};
    if (rst || !re1 || (raddr1 == {ADDR_W{1'b0}})) begin
      rdata1_s = {DATA_W{1'b0}};
    end else if ((raddr1 == wb_wd) && wr_act_s) begin
      rdata1_s = byte_merge(regs_r[raddr1], wb_wdata, eff_we_s);
    end else begin
      rdata1_s = regs_r[raddr1];
    end
  end

  // Read port 2: identical rules to port 1, fully independent.
  always_comb begin
    rdata2_s = {DATA_W{1'b0}};
    if (rst || !re2 || (raddr2 == {ADDR_W{1'b0}})) begin
      rdata2_s = {DATA_W{1'b0}};
    end else if ((raddr2 == wb_wd) && wr_act_s) begin
      rdata2_s = byte_merge(regs_r[raddr2], wb_wdata, eff_we_s);
    end else begin
      rdata2_s = regs_r[raddr2];
    end
  end

  assign rdata1 = rdata1_s;
  assign rdata2 = rdata2_s;

  // Register storage: clear on reset, otherwise commit the merged word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_act_s) begin
      regs_r[wb_wd] <= merged_s;
    end else begin
      regs_r[wb_wd] <= regs_r[wb_wd];
    end
  end

  // Commit trace: snapshot of what was committed at this edge; index and
  // data read as zero when nothing committed.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_pc_r    <= 32'd0;
      dbg_wen_r   <= {WE_W{1'b0}};
      dbg_wnum_r  <= {ADDR_W{1'b0}};
      dbg_wdata_r <= {DATA_W{1'b0}};
    end else if (wr_act_s) begin
      dbg_pc_r    <= wb_pc;
      dbg_wen_r   <= eff_we_s;
      dbg_wnum_r  <= wb_wd;
      dbg_wdata_r <= merged_s;
    end else begin
      dbg_pc_r    <= wb_pc;
      dbg_wen_r   <= {WE_W{1'b0}};
      dbg_wnum_r  <= {ADDR_W{1'b0}};
      dbg_wdata_r <= {DATA_W{1'b0}};
    end
  end

  // Commit counter: one per effective write, free-running wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 32'd0;
    end else if (wr_act_s) begin
      cnt_r <= cnt_r + 32'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign debug_wb_pc       = dbg_pc_r;
  assign debug_wb_rf_wen   = dbg_wen_r;
  assign debug_wb_rf_wnum  = dbg_wnum_r;
  assign debug_wb_rf_wdata = dbg_wdata_r;
  assign commit_cnt        = cnt_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected values tagged
// with the cycle in which they must be visible; a monitor compares them on
// the falling edge of that cycle.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [3:0]  wb_wreg;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata;
  logic [31:0] wb_pc;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] commit_cnt;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata), .wb_pc(wb_pc),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .commit_cnt(commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_RD1 = 0, S_RD2 = 1, S_PC = 2, S_WEN = 3,
                 S_WNUM = 4, S_WDATA = 5, S_CNT = 6;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      S_RD1:   return rdata1;
      S_RD2:   return rdata2;
      S_PC:    return debug_wb_pc;
      S_WEN:   return {28'd0, debug_wb_rf_wen};
      S_WNUM:  return {27'd0, debug_wb_rf_wnum};
      S_WDATA: return debug_wb_rf_wdata;
      S_CNT:   return commit_cnt;
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  // Monitor: check every queued expectation due in the current cycle.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        logic [31:0] a;
        a = actual(q[i].sig);
        total = total + 1;
        if (a !== q[i].exp) begin
          bad = bad + 1;
          $display("FAIL %s (cycle %0d): got %h expected %h", q[i].name, cyc, a, q[i].exp);
        end
        q.delete(i);
      end
    end
  end

  task automatic expect_at(input int ofs, input int sig, input logic [31:0] exp, input string name);
    chk_t c;
    c.cyc = cyc + ofs;
    c.sig = sig;
    c.exp = exp;
    c.name = name;
    q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] we, input logic [4:0] wd, input logic [31:0] d, input logic [31:0] pc);
    wb_wreg = we; wb_wd = wd; wb_wdata = d; wb_pc = pc;
  endtask

  task automatic rd(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
  endtask

  initial begin
    // Reset with a write pending on the bus: must be dropped.
    rst = 1'b1;
    wr(4'hF, 5'd5, 32'h12345678, 32'h0);
    rd(1'b1, 5'd5, 1'b0, 5'd0);
    step();
    expect_at(0, S_RD1, 32'h0, "rst_rd1");
    step();
    expect_at(0, S_RD1, 32'h0, "rst_rd1_b");
    expect_at(0, S_CNT, 32'h0, "rst_cnt");
    expect_at(0, S_WEN, 32'h0, "rst_wen");
    expect_at(0, S_PC,  32'h0, "rst_pc");

    // First cycle out of reset: r5 reads 0, full write to r3.
    rst = 1'b0;
    wr(4'hF, 5'd3, 32'hDEADBEEF, 32'hBFC00010);
    expect_at(0, S_RD1,   32'h0,        "post_rst_r5");
    expect_at(1, S_PC,    32'hBFC00010, "full_pc");
    expect_at(1, S_WNUM,  32'd3,        "full_wnum");
    expect_at(1, S_WDATA, 32'hDEADBEEF, "full_wdata");
    expect_at(1, S_WEN,   32'hF,        "full_wen");
    expect_at(1, S_CNT,   32'd1,        "full_cnt");
    step();

    // Read back r3, no write.
    wr(4'h0, 5'd3, 32'h0, 32'hBFC00014);
    rd(1'b1, 5'd3, 1'b0, 5'd0);
    expect_at(0, S_RD1,   32'hDEADBEEF, "read_r3");
    expect_at(1, S_WEN,   32'h0,        "idle_wen");
    expect_at(1, S_WNUM,  32'h0,        "idle_wnum");
    expect_at(1, S_WDATA, 32'h0,        "idle_wdata");
    expect_at(1, S_PC,    32'hBFC00014, "idle_pc");
    expect_at(1, S_CNT,   32'd1,        "idle_cnt");
    step();

    // Byte merge with same-cycle bypass on both ports.
    wr(4'b0010, 5'd3, 32'h0000AA00, 32'hBFC00018);
    rd(1'b1, 5'd3, 1'b1, 5'd3);
    expect_at(0, S_RD2,   32'hDEADAAEF, "bypass_rd2");
    expect_at(0, S_RD1,   32'hDEADAAEF, "bypass_rd1");
    expect_at(1, S_WEN,   32'h2,        "merge_wen");
    expect_at(1, S_WNUM,  32'd3,        "merge_wnum");
    expect_at(1, S_WDATA, 32'hDEADAAEF, "merge_wdata");
    expect_at(1, S_CNT,   32'd2,        "merge_cnt");
    step();

    // Write to r0 is discarded; r3 holds merged value.
    wr(4'hF, 5'd0, 32'hFFFFFFFF, 32'hBFC0001C);
    rd(1'b1, 5'd0, 1'b1, 5'd3);
    expect_at(0, S_RD1,   32'h0,        "r0_read");
    expect_at(0, S_RD2,   32'hDEADAAEF, "merge_stored");
    expect_at(1, S_WEN,   32'h0,        "r0_wen");
    expect_at(1, S_WDATA, 32'h0,        "r0_wdata");
    expect_at(1, S_CNT,   32'd2,        "r0_cnt");
    step();

    // Disabled port reads 0; r0 still 0; seed r7.
    wr(4'hF, 5'd7, 32'h11111111, 32'h0);
    rd(1'b0, 5'd3, 1'b1, 5'd0);
    expect_at(0, S_RD1, 32'h0, "re1_off");
    expect_at(0, S_RD2, 32'h0, "r0_after");
    expect_at(1, S_CNT, 32'd3, "r7_cnt");
    step();

    // Collision: both ports read r7 while it is rewritten.
    wr(4'hF, 5'd7, 32'h22222222, 32'h0);
    rd(1'b1, 5'd7, 1'b1, 5'd7);
    expect_at(0, S_RD1,  32'h22222222, "coll_rd1");
    expect_at(0, S_RD2,  32'h22222222, "coll_rd2");
    expect_at(1, S_WNUM, 32'd7,        "coll_wnum");
    expect_at(1, S_CNT,  32'd4,        "coll_cnt");
    step();

    // Write to r8 must not disturb r7 reads.
    wr(4'hF, 5'd8, 32'h33333333, 32'h0);
    expect_at(0, S_RD1,   32'h22222222, "r8wr_rd1");
    expect_at(0, S_RD2,   32'h22222222, "r8wr_rd2");
    expect_at(1, S_WNUM,  32'd8,        "r8_wnum");
    expect_at(1, S_WDATA, 32'h33333333, "r8_wdata");
    step();

    // Back-to-back write to r9, then reset interrupts the stream.
    wr(4'hF, 5'd9, 32'hAAAAAAAA, 32'h0);
    rd(1'b1, 5'd8, 1'b1, 5'd7);
    expect_at(0, S_RD1, 32'h33333333, "read_r8");
    expect_at(0, S_RD2, 32'h22222222, "read_r7");
    expect_at(1, S_CNT, 32'd6,        "pre_rst_cnt");
    step();
    rst = 1'b1;
    wr(4'hF, 5'd10, 32'hBBBBBBBB, 32'h00000777);
    rd(1'b1, 5'd9, 1'b1, 5'd10);
    expect_at(0, S_RD1, 32'h0, "mid_rst_rd1");
    expect_at(0, S_RD2, 32'h0, "mid_rst_rd2");
    expect_at(1, S_CNT, 32'h0, "mid_rst_cnt");
    expect_at(1, S_WEN, 32'h0, "mid_rst_wen");
    expect_at(1, S_PC,  32'h0, "mid_rst_pc");
    step();
    rst = 1'b0;
    wr(4'hF, 5'd10, 32'hCCCCCCCC, 32'h00001234);
    expect_at(0, S_RD1,   32'h0,        "r9_cleared");
    expect_at(0, S_RD2,   32'hCCCCCCCC, "post_rst_bypass");
    expect_at(1, S_CNT,   32'd1,        "post_rst_cnt");
    expect_at(1, S_WNUM,  32'd10,       "post_rst_wnum");
    expect_at(1, S_WDATA, 32'hCCCCCCCC, "post_rst_wdata");
    expect_at(1, S_PC,    32'h00001234, "post_rst_pc");
    step();
    wr(4'h0, 5'd0, 32'h0, 32'h0);
    rd(1'b1, 5'd10, 1'b0, 5'd0);
    expect_at(0, S_RD1, 32'hCCCCCCCC, "r10_stored");
    step();

    // Counter wrap: preload the count, then one more write.
    force dut.cnt_r = 32'hFFFFFFFF;
    #1;
    release dut.cnt_r;
    wr(4'hF, 5'd1, 32'h00000005, 32'h0);
    expect_at(0, S_CNT, 32'hFFFFFFFF, "cnt_preload");
    expect_at(1, S_CNT, 32'h0,        "cnt_wrap");
    step();
    wr(4'h0, 5'd0, 32'h0, 32'h0);

    // Drain: allow pending checks to fire, bounded.
    for (int i = 0; i < 4 && q.size() != 0; i++) step();
    if (q.size() != 0) begin
      for (int i = 0; i < q.size(); i++) begin
        total = total + 1;
        bad = bad + 1;
        $display("FAIL %s: check never reached, expected %h", q[i].name, q[i].exp);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
